// File: rtl/mcycle_ctrl.sv
// ---------------------------------------------------------------------------
// | Module   : mcycle_ctrl                                                   |
// | Function : multi-cycle RISC-V control FSM with bus timeout and instret   |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mcycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32,
  parameter int EN_JUMP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             branch,
  output logic             jump,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             alu_src,
  output logic             reg_write,
  output logic [2:0]       aluop,
  output logic [2:0]       state,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;

  localparam int              c_TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TLIM = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [6:0]       r_opcode;
  logic [c_TW-1:0]  r_tcnt;
  logic [c_TW-1:0]  w_tcnt_nxt;
  logic [CNT_W-1:0] r_instret;
  logic             r_cause_bus;

  logic       w_legal, w_is_br, w_is_jmp, w_is_ld, w_is_st;
  logic [2:0] w_aluop;
  logic       w_asrc, w_m2r;
  logic       w_tmo, w_ir_load, w_retire, w_cause_set, w_cause_bus;
  logic       w_unused_rdata;

  assign w_unused_rdata = ^imem_rdata[31:7];
  assign w_tmo          = (TIMEOUT != 0) && (r_tcnt == c_TLIM);
  assign state          = r_state;
  assign instret        = r_instret;

  // Opcode classification; illegal opcodes leave every datapath control at 0.
  always_comb begin
    w_legal  = 1'b1;
    w_is_br  = 1'b0;
    w_is_jmp = 1'b0;
    w_is_ld  = 1'b0;
    w_is_st  = 1'b0;
    w_aluop  = 3'b000;
    w_asrc   = 1'b0;
    w_m2r    = 1'b0;
    case (r_opcode)
      c_OP_R:     w_aluop = 3'b010;
      c_OP_I:     begin w_aluop = 3'b011; w_asrc = 1'b1; end
      c_OP_LOAD:  begin w_is_ld = 1'b1; w_asrc = 1'b1; w_m2r = 1'b1; end
      c_OP_STORE: begin w_is_st = 1'b1; w_asrc = 1'b1; end
      c_OP_BR:    begin w_aluop = 3'b001; w_is_br = 1'b1; end
      c_OP_LUI:   begin w_aluop = 3'b100; w_asrc = 1'b1; end
      c_OP_AUIPC: begin w_aluop = 3'b101; w_asrc = 1'b1; end
      c_OP_JAL: begin
        if (EN_JUMP != 0) w_is_jmp = 1'b1;
        else              w_legal  = 1'b0;
      end
      c_OP_JALR: begin
        if (EN_JUMP != 0) begin w_is_jmp = 1'b1; w_asrc = 1'b1; end
        else              w_legal  = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Next state and outputs; everything stays 0 while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = '0;
    w_ir_load   = 1'b0;
    w_retire    = 1'b0;
    w_cause_set = 1'b0;
    w_cause_bus = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem2reg     = 1'b0;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    aluop       = 3'b000;
    illegal_op  = 1'b0;
    bus_err     = 1'b0;
    if (rst_n) begin
      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        aluop   = w_aluop;
        alu_src = w_asrc;
        mem2reg = w_m2r;
      end
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we       = 1'b1;
            pc_we       = 1'b1;
            w_ir_load   = 1'b1;
            w_state_nxt = S_DECODE;
          end else if (w_tmo) begin
            w_state_nxt = S_TRAP;
            w_cause_set = 1'b1;
            w_cause_bus = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + c_TW'(1);
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_TRAP;
            w_cause_set = 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_br) begin
            branch      = 1'b1;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end else if (w_is_jmp) begin
            jump        = 1'b1;
            w_state_nxt = S_WB;
          end else if (w_is_ld || w_is_st) begin
            w_state_nxt = S_MEM;
          end else begin
            w_state_nxt = S_WB;
          end
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = w_is_ld;
          mem_write = w_is_st;
          if (dmem_ack) begin
            w_retire    = w_is_st;
            w_state_nxt = w_is_ld ? S_WB : S_FETCH;
          end else if (w_tmo) begin
            w_state_nxt = S_TRAP;
            w_cause_set = 1'b1;
            w_cause_bus = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + c_TW'(1);
          end
        end
        S_WB: begin
          reg_write   = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        S_TRAP: begin
          pc_we       = 1'b1;
          illegal_op  = ~r_cause_bus;
          bus_err     = r_cause_bus;
          w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_opcode    <= 7'd0;
      r_tcnt      <= '0;
      r_instret   <= '0;
      r_cause_bus <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_ir_load)   r_opcode    <= imem_rdata[6:0];
      if (w_retire)    r_instret   <= r_instret + CNT_W'(1);
      if (w_cause_set) r_cause_bus <= w_cause_bus;
    end
  end

endmodule

`default_nettype wire

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a memory request may wait for ack; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Parameter EN_JUMP, default 1: 1 decodes JAL/JALR; 0 treats them as illegal.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 imem_req / imem_ack  out / in  1 / 1  instruction fetch handshake.
REQ-007 imem_rdata  in  32  fetched instruction; bits [6:0] are the opcode.
REQ-008 dmem_req / dmem_ack  out / in  1 / 1  data memory handshake.
REQ-009 ir_we, pc_we  out  1  latch IR; advance PC by 4.
REQ-010 branch, jump, mem_read, mem_write, mem2reg, alu_src, reg_write  out  1  datapath controls.
REQ-011 aluop  out  3  ALU class: 010 R, 011 I, 000 load/store/jump, 001 branch, 100 LUI, 101 AUIPC.
REQ-012 state  out  3  current FSM state encoding.
REQ-013 illegal_op, bus_err  out  1  one-cycle error pulses.
REQ-014 instret  out  CNT_W  count of retired instructions.

Function
REQ-015 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 go to FETCH on the next edge.
REQ-016 FETCH: imem_req=1 until imem_ack; on ack, assert ir_we=1 and pc_we=1 for that cycle, register opcode=imem_rdata[6:0], go to DECODE.
REQ-017 Ack in the first cycle of FETCH is accepted, giving a 1-cycle fetch.
REQ-018 DECODE: one cycle; classify the registered opcode.
REQ-019 DECODE, illegal: any opcode outside 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, and 1101111/1100111 when EN_JUMP=1, goes to TRAP.
REQ-020 Control values: aluop, alu_src, mem2reg are driven from the registered opcode in DECODE, EXEC, MEM and WB.
REQ-021 alu_src=1 for I, load, store, LUI, AUIPC, JALR; 0 otherwise.
REQ-022 mem2reg=1 only for load.
REQ-023 EXEC: one cycle.
REQ-024 EXEC, branch: branch=1, then go to FETCH (branch retires here).
REQ-025 EXEC, JAL/JALR: jump=1, then go to WB.
REQ-026 EXEC, load/store: go to MEM.
REQ-027 EXEC, all other classes: go to WB.
REQ-028 MEM: dmem_req=1, with mem_read=1 for loads or mem_write=1 for stores, held until dmem_ack.
REQ-029 MEM, on ack: load goes to WB; store goes to FETCH (store retires here).
REQ-030 WB: reg_write=1 for one cycle, then go to FETCH.
REQ-031 Strobe exclusivity: reg_write, branch, jump, mem_read, mem_write, ir_we, pc_we are 0 in every state or cycle not named above.
REQ-032 Timeout counter: counts consecutive cycles with imem_req or dmem_req high and no ack; it clears on ack and on every state change.
REQ-033 Timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT with no ack, drop req and go to TRAP with bus_err=1.
REQ-034 Ack vs timeout: an ack in the same cycle the counter reaches TIMEOUT wins, so no error is raised.
REQ-035 TRAP: one cycle; pulse illegal_op or bus_err (whichever caused entry), assert pc_we=1 to skip the instruction, go to FETCH; instret is not incremented.
REQ-036 instret increments by 1 on each retirement: WB to FETCH, branch EXEC to FETCH, store MEM to FETCH.
REQ-037 instret wraps from 2^CNT_W-1 to 0.
REQ-038 Stray acks: imem_ack or dmem_ack arriving while the matching req is 0 is ignored.
REQ-039 Latency with 1-cycle acks: R/I/LUI/AUIPC/JAL/JALR 4 cycles; load 5; store 4; branch 3.

Reset
REQ-040 While rst_n=0 at a rising edge: state=FETCH, registered opcode=0, timeout counter=0, instret=0.
REQ-041 During reset all strobes and requests are 0, and aluop=000.
REQ-042 Reset asserted mid-operation (including mid-handshake) aborts the instruction; no retirement is counted.
REQ-043 In the first cycle after rst_n rises, imem_req=1.

Verification
REQ-044 Fetch 0x00B50533 (add), acks immediate -> states 0,1,2,4,0; reg_write high only in WB with aluop=010; instret 0->1.
REQ-045 Load 0x0002A303, dmem_ack delayed 3 cycles -> MEM lasts 4 cycles with mem_read=1, mem2reg=1; WB follows; total 8 cycles.
REQ-046 Opcode 0x7F -> TRAP after DECODE; illegal_op pulses once; pc_we=1; instret unchanged; the next cycle is FETCH.
REQ-047 TIMEOUT=4, imem_ack never given -> imem_req high 4 cycles, then TRAP with bus_err=1; ack on cycle 4 -> no error.
REQ-048 EN_JUMP=0 with JAL 0x0000006F -> illegal_op; EN_JUMP=1 -> jump=1 in EXEC and reg_write=1 in WB.
REQ-049 CNT_W=4, retire 17 instructions -> instret=1; reset mid-MEM -> state=0, instret=0 the next cycle.
